// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch queue.
// Field positions follow the RV32I base encoding.
package if_fetch_queue_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int OP_LSB  = 0;
  localparam int RD_LSB  = 7;
  localparam int FN3_LSB = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int FN7_LSB = 25;

  localparam int INSTR_ALIGN = 2;

  // Force a fetch address onto a word boundary.
  function automatic logic [31:0] align_pc(
    input logic [31:0] a
  );
    return {a[31:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// DEPTH x {pc,instr} ring buffer with occupancy count.
// Clear dominates any write/read in the same cycle.
module fetch_queue_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [63:0]              wr_data,
  input  logic                     rd_en,
  output logic [63:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Entry storage; needs no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  // Head entry is always read straight from storage.
  always_comb begin
    rd_data = mem[rptr];
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch front end: sequential PC requests to a 1-cycle BRAM,
// buffered in a small FIFO and handed to ID pre-split.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   CPU_CLK,
  input  logic                   CPU_RST,
  input  logic                   RedirectValid,
  input  logic [31:0]            RedirectTarget,
  output logic                   IReqValid,
  output logic [31:0]            IReqAddr,
  input  logic [31:0]            IRspData,
  output logic                   ValidD,
  input  logic                   ReadyD,
  output logic [31:0]            InstrD,
  output logic [31:0]            PCD,
  output logic [6:0]             OpD,
  output logic [2:0]             Fn3D,
  output logic [6:0]             Fn7D,
  output logic [4:0]             Rs1D,
  output logic [4:0]             Rs2D,
  output logic [4:0]             RdD,
  output logic [$clog2(DEPTH):0] CountQ
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0] fetch_pc;
  logic [31:0] inflight_pc;
  logic        inflight;
  logic        deq;
  logic        wr_en;
  logic [CW:0] credit;
  logic [63:0] head;

  fetch_queue_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (CPU_CLK),
    .rst    (CPU_RST),
    .clr    (RedirectValid),
    .wr_en  (wr_en),
    .wr_data({inflight_pc, IRspData}),
    .rd_en  (deq),
    .rd_data(head),
    .count  (CountQ)
  );

  // Handshake, credit and request address; a redirect always issues.
  always_comb begin
    ValidD = (CountQ != '0) && !RedirectValid;
    deq    = ValidD && ReadyD;
    wr_en  = inflight && !RedirectValid;
    credit = {1'b0, CountQ} + (CW+1)'(inflight)
           - (CW+1)'(deq);
    IReqValid = !CPU_RST
             && (RedirectValid || (credit < DEPTH_C));
    IReqAddr  = RedirectValid ? align_pc(RedirectTarget)
                              : fetch_pc;
  end

  // Next fetch address and the tag for the response in flight.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight    <= IReqValid;
      inflight_pc <= IReqAddr;
      if (IReqValid) fetch_pc <= IReqAddr + 32'd4;
    end
  end

  // Head presentation with NOP fill and decoder field split.
  always_comb begin
    InstrD = ValidD ? head[31:0]  : NOP_INSTR;
    PCD    = ValidD ? head[63:32] : 32'h0;
    OpD    = InstrD[OP_LSB  +: 7];
    Fn3D   = InstrD[FN3_LSB +: 3];
    Fn7D   = InstrD[FN7_LSB +: 7];
    Rs1D   = InstrD[RS1_LSB +: 5];
    Rs2D   = InstrD[RS2_LSB +: 5];
    RdD    = InstrD[RD_LSB  +: 5];
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: vector table for cold start,
// stall and redirect, then wrap-around and async-reset sequences.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv;
  logic [31:0] tgt;
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] rsp;
  logic        vd;
  logic        rdy;
  logic [31:0] instr;
  logic [31:0] pcd;
  logic [6:0]  op;
  logic [2:0]  fn3;
  logic [6:0]  fn7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [2:0]  cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vd;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  if_fetch_queue #(
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .CPU_CLK       (clk),
    .CPU_RST       (rst),
    .RedirectValid (rv),
    .RedirectTarget(tgt),
    .IReqValid     (ireq),
    .IReqAddr      (iaddr),
    .IRspData      (rsp),
    .ValidD        (vd),
    .ReadyD        (rdy),
    .InstrD        (instr),
    .PCD           (pcd),
    .OpD           (op),
    .Fn3D          (fn3),
    .Fn7D          (fn7),
    .Rs1D          (rs1),
    .Rs2D          (rs2),
    .RdD           (rd),
    .CountQ        (cnt)
  );

  // Instruction image: one real instruction, the rest addr-tagged.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h200) ? 32'h40B5_0533 : (a ^ 32'hC0DE_0000);
  endfunction

  // 1-cycle-latency BRAM; garbage when no request was made.
  always @(posedge clk) begin
    rsp <= ireq ? mem(iaddr) : 32'hBAD0_BAD0;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int r, input int v, input int t,
                     input int q, input int a, input int d,
                     input int p, input int c);
    vec_t x;
    x.rdy = r[0];
    x.rv = v[0];
    x.tgt = t;
    x.e_req = q[0];
    x.e_addr = a;
    x.e_vd = d[0];
    x.e_pc = p;
    x.e_cnt = c[2:0];
    vq.push_back(x);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int fires;

    rst = 1'b1;
    rv = 1'b0;
    tgt = '0;
    rdy = 1'b0;

    //  rdy rv tgt    req addr   vd pc     cnt
    add(1, 0, 0,      1, 'h0,   0, 0,     0);
    add(1, 0, 0,      1, 'h4,   0, 0,     0);
    add(1, 0, 0,      1, 'h8,   1, 'h0,   1);
    add(1, 0, 0,      1, 'hC,   1, 'h4,   1);
    add(0, 0, 0,      1, 'h10,  1, 'h8,   1);
    add(0, 0, 0,      1, 'h14,  1, 'h8,   2);
    add(0, 0, 0,      0, 'h18,  1, 'h8,   3);
    for (int k = 0; k < 7; k++)
      add(0, 0, 0,    0, 'h18,  1, 'h8,   4);
    add(1, 0, 0,      1, 'h18,  1, 'h8,   4);
    add(1, 0, 0,      1, 'h1C,  1, 'hC,   3);
    add(1, 0, 0,      1, 'h20,  1, 'h10,  3);
    add(1, 0, 0,      1, 'h24,  1, 'h14,  3);
    add(1, 1, 'h103,  1, 'h100, 0, 0,     3);
    add(1, 0, 0,      1, 'h104, 0, 0,     0);
    add(1, 0, 0,      1, 'h108, 1, 'h100, 1);
    add(1, 0, 0,      1, 'h10C, 1, 'h104, 1);
    add(1, 1, 'h202,  1, 'h200, 0, 0,     1);
    add(1, 0, 0,      1, 'h204, 0, 0,     0);
    add(1, 0, 0,      1, 'h208, 1, 'h200, 1);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ireq",  {31'b0, ireq}, 32'h0);
    chk("rst_vd",    {31'b0, vd},   32'h0);
    chk("rst_instr", instr,         32'h13);
    chk("rst_pcd",   pcd,           32'h0);
    chk("rst_cnt",   {29'b0, cnt},  32'h0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst = 1'b0;
      rdy = vq[i].rdy;
      rv  = vq[i].rv;
      tgt = vq[i].tgt;
      #1;
      chk($sformatf("v%0d_ireq", i), {31'b0, ireq},
          {31'b0, vq[i].e_req});
      if (vq[i].e_req)
        chk($sformatf("v%0d_addr", i), iaddr, vq[i].e_addr);
      chk($sformatf("v%0d_vd", i), {31'b0, vd},
          {31'b0, vq[i].e_vd});
      chk($sformatf("v%0d_pcd", i), pcd, vq[i].e_pc);
      chk($sformatf("v%0d_instr", i), instr,
          vq[i].e_vd ? mem(vq[i].e_pc) : 32'h13);
      chk($sformatf("v%0d_cnt", i), {29'b0, cnt},
          {29'b0, vq[i].e_cnt});
    end

    chk("fld_op",  {25'b0, op},  32'h33);
    chk("fld_fn3", {29'b0, fn3}, 32'h0);
    chk("fld_fn7", {25'b0, fn7}, 32'h20);
    chk("fld_rs1", {27'b0, rs1}, 32'd10);
    chk("fld_rs2", {27'b0, rs2}, 32'd11);
    chk("fld_rd",  {27'b0, rd},  32'd10);

    exp_pc = 32'h204;
    fires = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      chk("wrap_cnt_le_depth", {31'b0, cnt <= 3'd4}, 32'h1);
      if (vd && rdy) begin
        chk("wrap_pcd", pcd, exp_pc);
        chk("wrap_instr", instr, mem(exp_pc));
        exp_pc = exp_pc + 32'd4;
        fires++;
      end
    end
    chk("wrap_fires_min", {31'b0, fires >= 13}, 32'h1);

    @(negedge clk);
    rv = 1'b1;
    tgt = 32'h300;
    rdy = 1'b0;
    #1;
    chk("ar_redir_addr", iaddr, 32'h300);
    @(negedge clk);
    rv = 1'b0;
    #1;
    chk("ar_cnt0", {29'b0, cnt}, 32'h0);
    @(negedge clk);
    #1;
    chk("ar_cnt1", {29'b0, cnt}, 32'h1);
    @(negedge clk);
    #1;
    chk("ar_cnt2", {29'b0, cnt}, 32'h2);
    chk("ar_pcd_pre", pcd, 32'h300);
    rst = 1'b1;
    #1;
    chk("ar_vd",    {31'b0, vd},   32'h0);
    chk("ar_instr", instr,         32'h13);
    chk("ar_cnt",   {29'b0, cnt},  32'h0);
    chk("ar_pcd",   pcd,           32'h0);
    chk("ar_ireq",  {31'b0, ireq}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    rdy = 1'b1;
    #1;
    chk("rs_ireq0", {31'b0, ireq}, 32'h1);
    chk("rs_addr0", iaddr, 32'h0);
    @(negedge clk);
    #1;
    chk("rs_addr1", iaddr, 32'h4);
    chk("rs_vd1", {31'b0, vd}, 32'h0);
    @(negedge clk);
    #1;
    chk("rs_vd2", {31'b0, vd}, 32'h1);
    chk("rs_pcd2", pcd, 32'h0);
    chk("rs_instr2", instr, mem(32'h0));
    @(negedge clk);
    #1;
    chk("rs_pcd3", pcd, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch front end for the RV32I pipeline.
- Generates sequential PC requests to the synchronous instruction BRAM, which has 1-cycle read latency.
- Buffers the returned {PC, instruction} pairs in a DEPTH-entry FIFO.
- Presents the head entry to the ID stage, pre-split into the Op/Fn3/Fn7/register fields that the instruction decoder consumes.
- Absorbs ID stalls without losing fetched instructions.
- Flushes and restarts on branch/jump redirects.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- CPU_CLK  in  1  clock; all state changes on rising edge.
- CPU_RST  in  1  reset, asynchronous, active-high.
- RedirectValid  in  1  taken branch/JAL/JALR resolved this cycle.
- RedirectTarget  in  32  new fetch address; bits[1:0] are ignored (treated as 0).
- IReqValid  out  1  BRAM read enable this cycle.
- IReqAddr  out  32  BRAM byte address, word aligned.
- IRspData  in  32  BRAM data; valid exactly one cycle after IReqValid.
- ValidD  out  1  head entry is valid for ID.
- ReadyD  in  1  ID accepts the head; low means stall.
- InstrD  out  32  head instruction; 32'h0000_0013 (NOP) when ValidD=0.
- PCD  out  32  head PC; 0 when ValidD=0.
- OpD  out  7  InstrD[6:0].
- Fn3D  out  3  InstrD[14:12].
- Fn7D  out  7  InstrD[31:25].
- Rs1D  out  5  InstrD[19:15].
- Rs2D  out  5  InstrD[24:20].
- RdD  out  5  InstrD[11:7].
- CountQ  out  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, CPU_RST=1):
  - FetchPC=RESET_PC; FIFO empty; pointers 0; InflightQ=0.
  - Outputs: IReqValid=0, ValidD=0, InstrD=NOP, PCD=0, CountQ=0.
  - Reset asserted mid-operation discards all entries and any in-flight response.
- Deq fire: ValidD && ReadyD.
  - ValidD = (CountQ!=0) && !RedirectValid.
  - On fire, the read pointer advances by 1 and wraps modulo DEPTH.
- Request credit: IReqValid = !CPU_RST && ((CountQ + InflightQ - DeqFire) < DEPTH), or RedirectValid.
  - The DeqFire term gives a combinational path from ReadyD, so a full-rate stream of 1 instr/cycle is sustained at DEPTH >= 2.
- Request address:
  - RedirectValid=1: IReqAddr = {RedirectTarget[31:2],2'b00}, and FetchPC <= that address + 4.
  - Otherwise: IReqAddr = FetchPC, and FetchPC <= FetchPC + 4 when issued. Increment wraps modulo 2^32.
- In-flight tracking:
  - InflightQ <= IReqValid each cycle.
  - InflightPC <= IReqAddr.
- Response (cycle after a request):
  - If InflightQ && !RedirectValid: write {InflightPC, IRspData} at the write pointer, which advances and wraps.
  - Credit rule guarantees no write when full. A write when full is an assertion failure in the bench.
- Redirect cycle:
  - Next edge: FIFO cleared, CountQ=0.
  - The response arriving in that cycle is dropped.
  - A request to the target is issued in the same cycle, so it is never dropped.
- Redirect latency: redirect at cycle t → request at t, data at t+1, written at end of t+1, ValidD=1 at t+2 with PCD=target.
- Simultaneous enqueue+dequeue: CountQ unchanged; both pointers advance.
- Stall (ReadyD=0): head outputs held stable. Fetching continues until CountQ+InflightQ=DEPTH, then IReqValid=0.
- Cold start: first request the cycle after reset deassertion; first ValidD two cycles later.
- There is no empty-FIFO bypass; all outputs come from registered storage.

Decomposition:
- Shared package holds:
  - NOP_INSTR=32'h0000_0013.
  - Field bit-position constants for OP, FN3, FN7, RS1, RS2, RD.
  - INSTR_ALIGN=2.
- Sub-module fetch_queue_fifo:
  - Parameterised DEPTH × 64-bit {pc,instr} storage.
  - Write/read pointers with wrap, occupancy counter, synchronous clear input.
  - Same clock and async reset.
- Top level holds FetchPC, the in-flight registers, the credit logic and field splitting.

Test Plan:
- Reset release, RESET_PC=0, ReadyD=1, BRAM returns addr-tagged data.
  - Required: IReqAddr sequence 0,4,8,…
  - Required: ValidD first high 2 cycles after the first request, PCD=0, then one instruction per cycle.
- Stall: ReadyD=0 for 10 cycles at DEPTH=4.
  - Required: IReqValid drops once CountQ+InflightQ=4; CountQ saturates at 4.
  - Required: head PCD held constant; after ReadyD=1, PCs continue with no gaps or duplicates.
- Redirect with RedirectTarget=32'h0000_0103 while CountQ=3 and a response is in flight.
  - Required: IReqAddr=32'h100 that cycle; stale data is never presented.
  - Required: ValidD reasserts 2 cycles later with PCD=32'h100, then 32'h104.
- Wrap-around: run 3×DEPTH+1 instructions with random ReadyD.
  - Required: PC/instr order preserved through pointer wrap.
  - Required: CountQ never exceeds DEPTH.
- Async reset asserted mid-stream with CountQ=2.
  - Required: ValidD=0, InstrD=32'h13, and CountQ=0 immediately (before the next clock edge).
  - Required: refetch restarts at RESET_PC.
- Field split with head instruction 32'h40B5_0533 (sub x10,x10,x11).
  - Required: OpD=7'h33, Fn3D=0, Fn7D=7'h20, Rs1D=10, Rs2D=11, RdD=10.
